kairo_dbg_inst_gen: RTL and testbench

Debug-side instruction encoder that drives the core's injected-instruction port, in the opposite direction to the core's decoder. It accepts abstract debug commands: GPR read/write, CSR read/write, word load/store. Each command expands into a fixed sequence of RV32I/Zicsr instruction words. Words are issued one at a time, each retirement is awaited, and a single-cycle response reports completion or error.

---
 rtl/kairo_dbg_inst_gen.sv | 260 ++++++++++++++++++++++++++
 tb/tb_kairo_dbg_inst_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kairo_dbg_inst_gen.sv
// ============================================================================
// kairo_dbg_inst_gen : expands abstract debug commands into RV32I/Zicsr words
//                      injected one at a time into the core, awaiting retire.
// Rev 1.0
// ============================================================================
`default_nettype none

module kairo_dbg_inst_gen #(
  parameter logic [11:0] SCRATCH0_CSR   = 12'h7B2,
  parameter logic [11:0] SCRATCH1_CSR   = 12'h7B3,
  parameter logic [4:0]  TMP_A          = 5'd8,
  parameter logic [4:0]  TMP_B          = 5'd9,
  parameter int          RETIRE_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [2:0]  CMD_OP,
  input  logic [11:0] CMD_REGNO,
  input  logic [31:0] CMD_ADDR,
  output logic        INST_VALID,
  input  logic        INST_READY,
  output logic [31:0] INST_CODE,
  input  logic        INST_RETIRE,
  input  logic        INST_EXC,
  output logic        RSP_VALID,
  output logic        RSP_ERR,
  output logic        BUSY
);

  localparam logic [2:0] c_OP_GPR_RD = 3'd0;
  localparam logic [2:0] c_OP_GPR_WR = 3'd1;
  localparam logic [2:0] c_OP_CSR_RD = 3'd2;
  localparam logic [2:0] c_OP_CSR_WR = 3'd3;
  localparam logic [2:0] c_OP_LW     = 3'd4;
  localparam logic [2:0] c_OP_SW     = 3'd5;

  localparam logic [2:0] c_F3_CSRRW  = 3'b001;
  localparam logic [2:0] c_F3_CSRRS  = 3'b010;
  localparam logic [4:0] c_X0        = 5'd0;

  localparam int                c_CNT_W        = $clog2(RETIRE_TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(RETIRE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [2:0]           r_op;
  logic [11:0]          r_regno;
  logic [31:0]          r_addr;
  logic [2:0]           r_step;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_err;
  logic                 r_cmd_ready;
  logic                 r_busy;
  logic                 r_inst_valid;
  logic [31:0]          r_inst_code;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;

  logic [2:0]           w_last;
  logic [2:0]           w_first_restore;
  logic [2:0]           w_next_step;
  logic                 w_illegal;

  function automatic logic [31:0] f_csr(input logic [11:0] csr, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {csr, rs1, f3, rd, 7'b1110011};
  endfunction

  // Instruction word for one step of a command's fixed sequence
  function automatic logic [31:0] f_encode(input logic [2:0] op, input logic [11:0] regno,
                                           input logic [31:0] addr, input logic [2:0] step);
    logic [19:0] hi;
    logic [11:0] lo;
    logic [4:0]  n;
    hi = 20'((addr + 32'h0000_0800) >> 12);
    lo = addr[11:0];
    n  = regno[4:0];
    f_encode = 32'h0;
    case (op)
      c_OP_GPR_RD: f_encode = f_csr(SCRATCH0_CSR, n, c_F3_CSRRW, c_X0);
      c_OP_GPR_WR: f_encode = f_csr(SCRATCH0_CSR, c_X0, c_F3_CSRRS, n);
      c_OP_CSR_RD: begin
        case (step)
          3'd0:    f_encode = f_csr(SCRATCH1_CSR, TMP_A, c_F3_CSRRW, c_X0);
          3'd1:    f_encode = f_csr(regno, c_X0, c_F3_CSRRS, TMP_A);
          3'd2:    f_encode = f_csr(SCRATCH0_CSR, TMP_A, c_F3_CSRRW, c_X0);
          default: f_encode = f_csr(SCRATCH1_CSR, c_X0, c_F3_CSRRS, TMP_A);
        endcase
      end
      c_OP_CSR_WR: begin
        case (step)
          3'd0:    f_encode = f_csr(SCRATCH1_CSR, TMP_A, c_F3_CSRRW, c_X0);
          3'd1:    f_encode = f_csr(SCRATCH0_CSR, c_X0, c_F3_CSRRS, TMP_A);
          3'd2:    f_encode = f_csr(regno, TMP_A, c_F3_CSRRW, c_X0);
          default: f_encode = f_csr(SCRATCH1_CSR, c_X0, c_F3_CSRRS, TMP_A);
        endcase
      end
      c_OP_LW: begin
        case (step)
          3'd0:    f_encode = f_csr(SCRATCH1_CSR, TMP_A, c_F3_CSRRW, c_X0);
          3'd1:    f_encode = {hi, TMP_A, 7'b0110111};
          3'd2:    f_encode = {lo, TMP_A, 3'b010, TMP_A, 7'b0000011};
          3'd3:    f_encode = f_csr(SCRATCH0_CSR, TMP_A, c_F3_CSRRW, c_X0);
          default: f_encode = f_csr(SCRATCH1_CSR, c_X0, c_F3_CSRRS, TMP_A);
        endcase
      end
      c_OP_SW: begin
        // Data arrives in TMP_A by swapping with SCRATCH0; the swap back restores it
        case (step)
          3'd0:    f_encode = f_csr(SCRATCH0_CSR, TMP_A, c_F3_CSRRW, TMP_A);
          3'd1:    f_encode = f_csr(SCRATCH1_CSR, TMP_B, c_F3_CSRRW, c_X0);
          3'd2:    f_encode = {hi, TMP_B, 7'b0110111};
          3'd3:    f_encode = {lo[11:5], TMP_A, TMP_B, 3'b010, lo[4:0], 7'b0100011};
          3'd4:    f_encode = f_csr(SCRATCH1_CSR, c_X0, c_F3_CSRRS, TMP_B);
          default: f_encode = f_csr(SCRATCH0_CSR, TMP_A, c_F3_CSRRW, TMP_A);
        endcase
      end
      default: f_encode = 32'h0;
    endcase
  endfunction

  function automatic logic [2:0] f_last(input logic [2:0] op);
    case (op)
      c_OP_CSR_RD, c_OP_CSR_WR: return 3'd3;
      c_OP_LW:                  return 3'd4;
      c_OP_SW:                  return 3'd5;
      default:                  return 3'd0;
    endcase
  endfunction

  // First restore step; a value past the last step means the sequence has none
  function automatic logic [2:0] f_first_restore(input logic [2:0] op);
    case (op)
      c_OP_CSR_RD, c_OP_CSR_WR: return 3'd3;
      c_OP_LW, c_OP_SW:         return 3'd4;
      default:                  return 3'd1;
    endcase
  endfunction

  assign w_last          = f_last(r_op);
  assign w_first_restore = f_first_restore(r_op);
  assign w_next_step     = r_step + 3'd1;
  assign w_illegal       = (CMD_OP > c_OP_SW) ||
                           ((CMD_OP == c_OP_GPR_RD || CMD_OP == c_OP_GPR_WR) &&
                            (CMD_REGNO[11:5] != 7'd0));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_op         <= 3'd0;
      r_regno      <= 12'd0;
      r_addr       <= 32'd0;
      r_step       <= 3'd0;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst_code  <= 32'd0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (CMD_VALID) begin
            r_op        <= CMD_OP;
            r_regno     <= CMD_REGNO;
            r_addr      <= CMD_ADDR;
            r_step      <= 3'd0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (w_illegal) begin
              r_err       <= 1'b1;
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_err        <= 1'b0;
              r_state      <= S_ISSUE;
              r_inst_valid <= 1'b1;
              r_inst_code  <= f_encode(CMD_OP, CMD_REGNO, CMD_ADDR, 3'd0);
            end
          end
        end

        S_ISSUE: begin
          if (INST_READY) begin
            r_state      <= S_WAIT;
            r_inst_valid <= 1'b0;
            r_inst_code  <= 32'd0;
            r_cnt        <= '0;
          end
        end

        S_WAIT: begin
          if (INST_EXC) begin
            r_err <= 1'b1;
            if ((r_step < w_first_restore) && (w_first_restore <= w_last)) begin
              r_step       <= w_first_restore;
              r_state      <= S_ISSUE;
              r_inst_valid <= 1'b1;
              r_inst_code  <= f_encode(r_op, r_regno, r_addr, w_first_restore);
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end
          end else if (INST_RETIRE) begin
            if (r_step == w_last) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= r_err;
            end else begin
              r_step       <= w_next_step;
              r_state      <= S_ISSUE;
              r_inst_valid <= 1'b1;
              r_inst_code  <= f_encode(r_op, r_regno, r_addr, w_next_step);
            end
          end else if (r_cnt == c_TIMEOUT_LAST) begin
            r_err       <= 1'b1;
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= 1'b0;
          r_rsp_err   <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CMD_READY  = r_cmd_ready;
  assign BUSY       = r_busy;
  assign INST_VALID = r_inst_valid;
  assign INST_CODE  = r_inst_code;
  assign RSP_VALID  = r_rsp_valid;
  assign RSP_ERR    = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_kairo_dbg_inst_gen.sv
// ============================================================================
// tb_kairo_dbg_inst_gen : table-driven bench for kairo_dbg_inst_gen
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kairo_dbg_inst_gen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [2:0]  CMD_OP;
  logic [11:0] CMD_REGNO;
  logic [31:0] CMD_ADDR;
  logic        INST_VALID;
  logic        INST_READY;
  logic [31:0] INST_CODE;
  logic        INST_RETIRE;
  logic        INST_EXC;
  logic        RSP_VALID;
  logic        RSP_ERR;
  logic        BUSY;

  int total = 0;
  int bad   = 0;

  kairo_dbg_inst_gen dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
    .CMD_REGNO(CMD_REGNO), .CMD_ADDR(CMD_ADDR),
    .INST_VALID(INST_VALID), .INST_READY(INST_READY), .INST_CODE(INST_CODE),
    .INST_RETIRE(INST_RETIRE), .INST_EXC(INST_EXC),
    .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0]        op;
    logic [11:0]       regno;
    logic [31:0]       addr;
    logic [3:0]        exc_at;   // issued-word index that gets INST_EXC, 15 = none
    logic              both;     // also pulse INST_RETIRE alongside INST_EXC
    logic [2:0]        stall;
    logic [2:0]        n;        // number of words expected on INST_CODE
    logic [0:5][31:0]  w;
    logic              err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [2:0] op, input logic [11:0] regno,
                              input logic [31:0] addr, input logic [3:0] exc_at,
                              input logic both, input logic [2:0] stall, input logic [2:0] n,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input logic [31:0] w4, input logic [31:0] w5,
                              input logic err);
    vec_t v;
    v.op = op; v.regno = regno; v.addr = addr; v.exc_at = exc_at; v.both = both;
    v.stall = stall; v.n = n; v.err = err;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3; v.w[4] = w4; v.w[5] = w5;
    return v;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_cmd_ready"}, -1, 32'(CMD_READY), 32'd1);
    chk({name, "_inst_valid"}, -1, 32'(INST_VALID), 32'd0);
    chk({name, "_inst_code"}, -1, INST_CODE, 32'd0);
    chk({name, "_rsp_valid"}, -1, 32'(RSP_VALID), 32'd0);
    chk({name, "_rsp_err"}, -1, 32'(RSP_ERR), 32'd0);
    chk({name, "_busy"}, -1, 32'(BUSY), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          t;
    logic [31:0] code;
    CMD_OP = v.op; CMD_REGNO = v.regno; CMD_ADDR = v.addr; CMD_VALID = 1'b1;
    tick;
    CMD_VALID = 1'b0;
    if (v.n == 3'd0) begin
      chk("illegal_inst_valid", idx, 32'(INST_VALID), 32'd0);
    end else begin
      chk("accept_cmd_ready", idx, 32'(CMD_READY), 32'd0);
      chk("accept_busy", idx, 32'(BUSY), 32'd1);
    end
    for (int k = 0; k < int'(v.n); k++) begin
      t = 0;
      while (!INST_VALID && !RSP_VALID && t < 20) begin
        tick;
        t++;
      end
      chk("word_valid", idx, 32'(INST_VALID), 32'd1);
      if (!INST_VALID) break;
      chk("word_code", idx, INST_CODE, v.w[k]);
      code = INST_CODE;
      // Unready core, with a stray command that must be ignored meanwhile
      for (int s = 0; s < int'(v.stall); s++) begin
        CMD_VALID = 1'b1; CMD_OP = 3'd6;
        tick;
        chk("stall_valid", idx, 32'(INST_VALID), 32'd1);
        chk("stall_code", idx, INST_CODE, code);
      end
      CMD_VALID = 1'b0;
      INST_READY = 1'b1;
      tick;
      INST_READY = 1'b0;
      chk("post_hs_valid", idx, 32'(INST_VALID), 32'd0);
      tick;
      if (k == int'(v.exc_at)) begin
        INST_EXC = 1'b1;
        INST_RETIRE = v.both;
      end else begin
        INST_RETIRE = 1'b1;
      end
      tick;
      INST_EXC = 1'b0;
      INST_RETIRE = 1'b0;
    end
    t = 0;
    while (!RSP_VALID && t < 20) begin
      tick;
      t++;
    end
    chk("rsp_valid", idx, 32'(RSP_VALID), 32'd1);
    chk("rsp_latency", idx, 32'(t), 32'd0);
    chk("rsp_err", idx, 32'(RSP_ERR), 32'(v.err));
    chk("rsp_no_inst", idx, 32'(INST_VALID), 32'd0);
    tick;
    chk("rsp_pulse_end", idx, 32'(RSP_VALID), 32'd0);
    chk("idle_ready", idx, 32'(CMD_READY), 32'd1);
    chk("idle_busy", idx, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int t;
    int seen;
    RST = 1'b1; CMD_VALID = 1'b0; CMD_OP = 3'd0; CMD_REGNO = 12'd0; CMD_ADDR = 32'd0;
    INST_READY = 1'b0; INST_RETIRE = 1'b0; INST_EXC = 1'b0;

    vecs[0]  = mk(3'd0, 12'd5,     32'h0, 4'd15, 1'b0, 3'd0, 3'd1,
                  32'h7B229073, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    vecs[1]  = mk(3'd1, 12'd10,    32'h0, 4'd15, 1'b0, 3'd3, 3'd1,
                  32'h7B202573, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    vecs[2]  = mk(3'd4, 12'd0, 32'h00001FFC, 4'd15, 1'b0, 3'd0, 3'd5,
                  32'h7B341073, 32'h00002437, 32'hFFC42403, 32'h7B241073, 32'h7B302473, 32'h0, 1'b0);
    vecs[3]  = mk(3'd4, 12'd0, 32'h00001FFC, 4'd2, 1'b0, 3'd0, 3'd4,
                  32'h7B341073, 32'h00002437, 32'hFFC42403, 32'h7B302473, 32'h0, 32'h0, 1'b1);
    vecs[4]  = mk(3'd2, 12'h300,   32'h0, 4'd15, 1'b0, 3'd0, 3'd4,
                  32'h7B341073, 32'h30002473, 32'h7B241073, 32'h7B302473, 32'h0, 32'h0, 1'b0);
    vecs[5]  = mk(3'd2, 12'h300,   32'h0, 4'd3, 1'b0, 3'd0, 3'd4,
                  32'h7B341073, 32'h30002473, 32'h7B241073, 32'h7B302473, 32'h0, 32'h0, 1'b1);
    vecs[6]  = mk(3'd3, 12'h305,   32'h0, 4'd15, 1'b0, 3'd2, 3'd4,
                  32'h7B341073, 32'h7B202473, 32'h30541073, 32'h7B302473, 32'h0, 32'h0, 1'b0);
    vecs[7]  = mk(3'd5, 12'd0, 32'h12345678, 4'd15, 1'b0, 3'd0, 3'd6,
                  32'h7B241473, 32'h7B349073, 32'h123454B7, 32'h6684AC23, 32'h7B3024F3, 32'h7B241473, 1'b0);
    vecs[8]  = mk(3'd5, 12'd0, 32'h12345678, 4'd0, 1'b0, 3'd0, 3'd3,
                  32'h7B241473, 32'h7B3024F3, 32'h7B241473, 32'h0, 32'h0, 32'h0, 1'b1);
    vecs[9]  = mk(3'd0, 12'd5,     32'h0, 4'd0, 1'b0, 3'd0, 3'd1,
                  32'h7B229073, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    vecs[10] = mk(3'd6, 12'd5,     32'h0, 4'd15, 1'b0, 3'd0, 3'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    vecs[11] = mk(3'd0, 12'h020,   32'h0, 4'd15, 1'b0, 3'd0, 3'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    vecs[12] = mk(3'd7, 12'd1,     32'h0, 4'd15, 1'b0, 3'd0, 3'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    vecs[13] = mk(3'd1, 12'd0,     32'h0, 4'd15, 1'b0, 3'd0, 3'd1,
                  32'h7B202073, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    vecs[14] = mk(3'd5, 12'd0, 32'h12345678, 4'd4, 1'b0, 3'd0, 3'd5,
                  32'h7B241473, 32'h7B349073, 32'h123454B7, 32'h6684AC23, 32'h7B3024F3, 32'h0, 1'b1);
    vecs[15] = mk(3'd4, 12'd0, 32'h00001FFC, 4'd1, 1'b1, 3'd0, 3'd3,
                  32'h7B341073, 32'h00002437, 32'h7B302473, 32'h0, 32'h0, 32'h0, 1'b1);

    tick; tick;
    chk_reset_vals("reset_held");
    RST = 1'b0;
    tick;
    chk_reset_vals("reset_released");

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Core never retires: timeout response
    CMD_OP = 3'd0; CMD_REGNO = 12'd5; CMD_ADDR = 32'd0; CMD_VALID = 1'b1;
    tick;
    CMD_VALID = 1'b0;
    chk("to_word", 100, INST_CODE, 32'h7B229073);
    INST_READY = 1'b1;
    tick;
    INST_READY = 1'b0;
    t = 0;
    while (!RSP_VALID && t < 400) begin
      tick;
      t++;
    end
    chk("to_rsp_valid", 100, 32'(RSP_VALID), 32'd1);
    chk("to_rsp_err", 100, 32'(RSP_ERR), 32'd1);
    chk("to_cycles_in_range", 100, 32'(t >= 254 && t <= 256), 32'd1);
    tick;
    chk("to_idle_ready", 100, 32'(CMD_READY), 32'd1);

    // Asynchronous reset while the second SW word is being offered
    CMD_OP = 3'd5; CMD_REGNO = 12'd0; CMD_ADDR = 32'h12345678; CMD_VALID = 1'b1;
    tick;
    CMD_VALID = 1'b0;
    INST_READY = 1'b1;
    tick;
    INST_READY = 1'b0;
    INST_RETIRE = 1'b1;
    tick;
    INST_RETIRE = 1'b0;
    chk("rst_mid_word1_valid", 101, 32'(INST_VALID), 32'd1);
    chk("rst_mid_word1_code", 101, INST_CODE, 32'h7B349073);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_vals("rst_mid_async");
    tick;
    RST = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (RSP_VALID || INST_VALID) seen = 1;
    end
    chk("rst_mid_no_activity", 101, 32'(seen), 32'd0);
    chk("rst_mid_idle_ready", 101, 32'(CMD_READY), 32'd1);
    run_vec(vecs[0], 102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
